// File: rtl/mips_mc_ctrl_pkg.sv
// mips_pkg: opcode/funct constants, FSM state encoding and datapath select
// encodings shared by the multi-cycle MIPS controller and its decoder.
`default_nettype none

package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_R     = 4'd8,
        S_WB_I     = 4'd9,
        S_WB_MEM   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_LUI = 3'd5
    } alu_op_t;

    typedef enum logic [1:0] {
        EXT_ZERO = 2'd0,
        EXT_SIGN = 2'd1,
        EXT_HIGH = 2'd2
    } ext_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'd0,
        PC_ALUOUT = 2'd1,
        PC_JUMP   = 2'd2,
        PC_RS     = 2'd3
    } pc_src_t;

    typedef enum logic [1:0] {
        RD_RT  = 2'd0,
        RD_RD  = 2'd1,
        RD_R31 = 2'd2
    } reg_dst_t;

    typedef enum logic [1:0] {
        M2R_ALU = 2'd0,
        M2R_MEM = 2'd1,
        M2R_PC  = 2'd2
    } mem_to_reg_t;

    typedef enum logic [1:0] {
        SRCB_REG    = 2'd0,
        SRCB_FOUR   = 2'd1,
        SRCB_IMM    = 2'd2,
        SRCB_BRANCH = 2'd3
    } alu_src_b_t;

    typedef enum logic [3:0] {
        CLS_ALU_R   = 4'd0,
        CLS_ORI     = 4'd1,
        CLS_LUI     = 4'd2,
        CLS_LW      = 4'd3,
        CLS_SW      = 4'd4,
        CLS_BEQ     = 4'd5,
        CLS_J       = 4'd6,
        CLS_JAL     = 4'd7,
        CLS_JR      = 4'd8,
        CLS_ILLEGAL = 4'd9
    } cls_t;

    // States that own the shared memory port and therefore run the wait counter.
    function automatic logic is_mem_state(state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_mc_ctrl_if.sv
// mips_mc_ctrl_if: shared memory port handshake between the controller
// (master) and the memory subsystem (slave).
`default_nettype none

interface mips_mc_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic i_or_d;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output i_or_d,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  i_or_d,
        output mem_ready
    );
endinterface

`default_nettype wire

// File: rtl/mips_mc_ctrl_decode.sv
// mips_mc_decode: combinational opcode/funct classifier; yields the
// instruction class, the ALU operation for the execute step and an illegal flag.
`default_nettype none

module mips_mc_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output cls_t       cls_o,
    output alu_op_t    alu_op_o,
    output logic       illegal_o
);

    always_comb begin
        cls_o    = CLS_ILLEGAL;
        alu_op_o = ALU_ADD;
        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADDU: begin cls_o = CLS_ALU_R; alu_op_o = ALU_ADD; end
                    FN_SUBU: begin cls_o = CLS_ALU_R; alu_op_o = ALU_SUB; end
                    FN_AND:  begin cls_o = CLS_ALU_R; alu_op_o = ALU_AND; end
                    FN_OR:   begin cls_o = CLS_ALU_R; alu_op_o = ALU_OR;  end
                    FN_SLT:  begin cls_o = CLS_ALU_R; alu_op_o = ALU_SLT; end
                    FN_JR:   cls_o = CLS_JR;
                    default: cls_o = CLS_ILLEGAL;
                endcase
            end
            OP_ORI:  begin cls_o = CLS_ORI; alu_op_o = ALU_OR;  end
            OP_LUI:  begin cls_o = CLS_LUI; alu_op_o = ALU_LUI; end
            OP_LW:   cls_o = CLS_LW;
            OP_SW:   cls_o = CLS_SW;
            OP_BEQ:  begin cls_o = CLS_BEQ; alu_op_o = ALU_SUB; end
            OP_J:    cls_o = CLS_J;
            OP_JAL:  cls_o = CLS_JAL;
            default: cls_o = CLS_ILLEGAL;
        endcase
    end

    assign illegal_o = (cls_o == CLS_ILLEGAL);

endmodule

`default_nettype wire

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle MIPS control FSM with a shared memory port,
// wait-state timeout and fault pulses. Optional counters: MIPS_MC_PERF_EN.
`default_nettype none

module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    mips_mc_ctrl_if.master     mem,
    input  logic [5:0]         opcode_i,
    input  logic [5:0]         funct_i,
    input  logic               zero_i,
    output logic               ir_write_o,
    output logic               pc_write_o,
    output logic               reg_write_o,
    output logic [1:0]         reg_dst_o,
    output logic [1:0]         mem_to_reg_o,
    output logic [1:0]         alu_src_b_o,
    output logic [1:0]         pc_src_o,
    output logic               alu_src_a_o,
    output logic [2:0]         alu_op_o,
    output logic [1:0]         ext_type_o,
    output logic               illegal_o,
    output logic               bus_err_o,
    output logic [3:0]         state_o
`ifdef MIPS_MC_PERF_EN
    ,
    output logic [CNT_W-1:0]   cycle_cnt_o,
    output logic [CNT_W-1:0]   instr_cnt_o
`endif
);

    localparam int unsigned     WAIT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;

    cls_t                dec_cls;
    alu_op_t             dec_alu_op;
    logic                dec_illegal;

    logic                mem_state;
    logic                expired;

    logic                mem_req, mem_we, i_or_d;
    logic                ir_write, pc_write, reg_write;
    reg_dst_t            reg_dst;
    mem_to_reg_t         mem_to_reg;
    alu_src_b_t          alu_src_b;
    pc_src_t             pc_src;
    logic                alu_src_a;
    alu_op_t             alu_op;
    ext_t                ext_type;
    logic                illegal;

    mips_mc_decode u_decode (
        .opcode_i  (opcode_i),
        .funct_i   (funct_i),
        .cls_o     (dec_cls),
        .alu_op_o  (dec_alu_op),
        .illegal_o (dec_illegal)
    );

    assign mem_state = is_mem_state(state_q);
    // A ready arriving in the expiry cycle completes the access instead of faulting.
    assign expired   = (TIMEOUT != 0) && mem_state && (wait_q == WAIT_MAX) && !mem.mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Counter runs only while an access stays pending; any completion, abandon
    // or state change (including the FETCH retry) starts the next access at 0.
    always_comb begin
        wait_d = '0;
        if (mem_state && !mem.mem_ready && !expired) begin
            wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = RD_RT;
        mem_to_reg = M2R_ALU;
        alu_src_b  = SRCB_REG;
        pc_src     = PC_ALU;
        alu_src_a  = 1'b0;
        alu_op     = ALU_ADD;
        ext_type   = EXT_ZERO;
        illegal    = 1'b0;

        case (state_q)
            S_RESET: state_d = S_FETCH;

            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (expired) begin
                    state_d = S_FETCH;
                end
            end

            S_DECODE: begin
                alu_src_b = SRCB_BRANCH;
                ext_type  = EXT_SIGN;
                illegal   = dec_illegal;
                case (dec_cls)
                    CLS_ALU_R:        state_d = S_EXEC_R;
                    CLS_ORI, CLS_LUI: state_d = S_EXEC_I;
                    CLS_LW, CLS_SW:   state_d = S_MEM_ADDR;
                    CLS_BEQ:          state_d = S_BRANCH;
                    CLS_J, CLS_JAL,
                    CLS_JR:           state_d = S_JUMP;
                    default:          state_d = S_FETCH;
                endcase
            end

            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = dec_alu_op;
                state_d   = S_WB_R;
            end

            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = dec_alu_op;
                if (dec_cls == CLS_LUI) begin
                    ext_type = EXT_HIGH;
                end else begin
                    ext_type = EXT_ZERO;
                end
                state_d   = S_WB_I;
            end

            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                ext_type  = EXT_SIGN;
                state_d   = (dec_cls == CLS_SW) ? S_MEM_WR : S_MEM_RD;
            end

            S_MEM_RD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                if (mem.mem_ready) begin
                    state_d = S_WB_MEM;
                end else if (expired) begin
                    state_d = S_FETCH;
                end
            end

            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                i_or_d  = 1'b1;
                if (mem.mem_ready || expired) begin
                    state_d = S_FETCH;
                end
            end

            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = RD_RD;
                state_d   = S_FETCH;
            end

            S_WB_I: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end

            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MEM;
                state_d    = S_FETCH;
            end

            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PC_ALUOUT;
                pc_write  = zero_i;
                state_d   = S_FETCH;
            end

            S_JUMP: begin
                pc_write = 1'b1;
                state_d  = S_FETCH;
                case (dec_cls)
                    CLS_JR:  pc_src = PC_RS;
                    CLS_JAL: begin
                        pc_src     = PC_JUMP;
                        reg_write  = 1'b1;
                        reg_dst    = RD_R31;
                        mem_to_reg = M2R_PC;
                    end
                    default: pc_src = PC_JUMP;
                endcase
            end

            default: state_d = S_RESET;
        endcase
    end

    assign mem.mem_req   = mem_req;
    assign mem.mem_we    = mem_we;
    assign mem.i_or_d    = i_or_d;

    assign ir_write_o    = ir_write;
    assign pc_write_o    = pc_write;
    assign reg_write_o   = reg_write;
    assign reg_dst_o     = reg_dst;
    assign mem_to_reg_o  = mem_to_reg;
    assign alu_src_b_o   = alu_src_b;
    assign pc_src_o      = pc_src;
    assign alu_src_a_o   = alu_src_a;
    assign alu_op_o      = alu_op;
    assign ext_type_o    = ext_type;
    assign illegal_o     = illegal;
    assign bus_err_o     = expired;
    assign state_o       = state_q;

`ifdef MIPS_MC_PERF_EN
    logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;
    logic             instr_done;

    // Retirement is the hand-back to FETCH from a terminal state; an illegal
    // opcode leaves from DECODE and is therefore not counted.
    assign instr_done = (state_d == S_FETCH) &&
                        (state_q inside {S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_MEM_WR});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (state_q != S_RESET) begin
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            end
            if (instr_done) begin
                instr_cnt_q <= instr_cnt_q + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt_o = cycle_cnt_q;
    assign instr_cnt_o = instr_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: directed and randomized instruction sequences checked
// cycle-by-cycle against an expected trace built from per-instruction phases.
`default_nettype none

module tb_mips_mc_ctrl;
    import mips_pkg::*;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode, funct;
    logic       zero;
    logic       ir_write, pc_write, reg_write, alu_src_a, illegal, bus_err;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src, ext_type;
    logic [2:0] alu_op;
    logic [3:0] state;
`ifdef MIPS_MC_PERF_EN
    logic [3:0] cycle_cnt, instr_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    string cur = "";

    always #5 clk = ~clk;

    mips_mc_ctrl_if mem_if ();

    mips_mc_ctrl #(.TIMEOUT(TO), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem          (mem_if.master),
        .opcode_i     (opcode),
        .funct_i      (funct),
        .zero_i       (zero),
        .ir_write_o   (ir_write),
        .pc_write_o   (pc_write),
        .reg_write_o  (reg_write),
        .reg_dst_o    (reg_dst),
        .mem_to_reg_o (mem_to_reg),
        .alu_src_b_o  (alu_src_b),
        .pc_src_o     (pc_src),
        .alu_src_a_o  (alu_src_a),
        .alu_op_o     (alu_op),
        .ext_type_o   (ext_type),
        .illegal_o    (illegal),
        .bus_err_o    (bus_err),
        .state_o      (state)
`ifdef MIPS_MC_PERF_EN
        ,
        .cycle_cnt_o  (cycle_cnt),
        .instr_cnt_o  (instr_cnt)
`endif
    );

    // One expected clock cycle: the mem_ready to apply and the outputs required.
    typedef struct {
        state_t     st;
        bit         rdy;
        bit         req, we, iod, irw, pcw, rw, ill, berr;
        logic [2:0] aop;
        logic [1:0] psrc, rdst, m2r;
    } cyc_t;

    cyc_t q[$];

    // Instruction kinds used by the stimulus.
    localparam int K_ADDU = 0, K_SUBU = 1, K_AND = 2, K_OR = 3, K_SLT = 4,
                   K_ORI = 5, K_LUI = 6, K_LW = 7, K_SW = 8, K_BEQ = 9,
                   K_J = 10, K_JAL = 11, K_JR = 12, K_BAD = 13;
    string nm[14] = '{"addu","subu","and","or","slt","ori","lui","lw","sw",
                      "beq","j","jal","jr","bad"};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic cyc_t blank(state_t s);
        cyc_t c;
        c.st = s;   c.rdy = 1'b0;
        c.req = 1'b0; c.we = 1'b0; c.iod = 1'b0; c.irw = 1'b0;
        c.pcw = 1'b0; c.rw = 1'b0; c.ill = 1'b0; c.berr = 1'b0;
        c.aop = 3'd0; c.psrc = 2'd0; c.rdst = 2'd0; c.m2r = 2'd0;
        return c;
    endfunction

    // A memory access with w not-ready cycles: completes after w waits, or is
    // abandoned with bus_err in its (TO+1)th cycle when w exceeds TO.
    task automatic mem_phase(input state_t s, input bit we, input int w, output bit ok);
        cyc_t c;
        int   n;
        ok = (w <= TO);
        n  = ok ? w : TO;
        for (int i = 0; i <= n; i++) begin
            c      = blank(s);
            c.req  = 1'b1;
            c.we   = we;
            c.iod  = (s != S_FETCH);
            c.rdy  = ok && (i == n);
            c.berr = !ok && (i == n);
            if (s == S_FETCH) begin
                c.irw = c.rdy;
                c.pcw = c.rdy;
            end
            q.push_back(c);
        end
    endtask

    task automatic build(input int k, input int fw, input int mw, input bit z);
        cyc_t c;
        bit   ok;
        mem_phase(S_FETCH, 1'b0, fw, ok);
        if (!ok) mem_phase(S_FETCH, 1'b0, 0, ok);
        c = blank(S_DECODE);
        c.ill = (k == K_BAD);
        q.push_back(c);
        case (k)
            K_ADDU, K_SUBU, K_AND, K_OR, K_SLT: begin
                c = blank(S_EXEC_R);
                case (k)
                    K_ADDU:  c.aop = 3'd0;
                    K_SUBU:  c.aop = 3'd1;
                    K_AND:   c.aop = 3'd2;
                    K_OR:    c.aop = 3'd3;
                    default: c.aop = 3'd4;
                endcase
                q.push_back(c);
                c = blank(S_WB_R); c.rw = 1'b1; c.rdst = 2'd1;
                q.push_back(c);
            end
            K_ORI, K_LUI: begin
                c = blank(S_EXEC_I);
                c.aop = (k == K_ORI) ? 3'd3 : 3'd5;
                q.push_back(c);
                c = blank(S_WB_I); c.rw = 1'b1; c.rdst = 2'd0;
                q.push_back(c);
            end
            K_LW: begin
                q.push_back(blank(S_MEM_ADDR));
                mem_phase(S_MEM_RD, 1'b0, mw, ok);
                if (ok) begin
                    c = blank(S_WB_MEM); c.rw = 1'b1; c.m2r = 2'd1;
                    q.push_back(c);
                end
            end
            K_SW: begin
                q.push_back(blank(S_MEM_ADDR));
                mem_phase(S_MEM_WR, 1'b1, mw, ok);
            end
            K_BEQ: begin
                c = blank(S_BRANCH); c.aop = 3'd1; c.psrc = 2'd1; c.pcw = z;
                q.push_back(c);
            end
            K_J, K_JAL, K_JR: begin
                c = blank(S_JUMP); c.pcw = 1'b1;
                c.psrc = (k == K_JR) ? 2'd3 : 2'd2;
                if (k == K_JAL) begin
                    c.rw = 1'b1; c.rdst = 2'd2; c.m2r = 2'd2;
                end
                q.push_back(c);
            end
            default: ;
        endcase
    endtask

    task automatic enc(input int k, output logic [5:0] op, output logic [5:0] fn);
        fn = 6'($urandom);
        case (k)
            K_ADDU: begin op = 6'h00; fn = 6'h21; end
            K_SUBU: begin op = 6'h00; fn = 6'h23; end
            K_AND:  begin op = 6'h00; fn = 6'h24; end
            K_OR:   begin op = 6'h00; fn = 6'h25; end
            K_SLT:  begin op = 6'h00; fn = 6'h2A; end
            K_ORI:  op = 6'h0D;
            K_LUI:  op = 6'h0F;
            K_LW:   op = 6'h23;
            K_SW:   op = 6'h2B;
            K_BEQ:  op = 6'h04;
            K_J:    op = 6'h02;
            K_JAL:  op = 6'h03;
            K_JR:   begin op = 6'h00; fn = 6'h08; end
            default: begin
                case ($urandom_range(0, 3))
                    0:       op = 6'h3F;
                    1:       op = 6'h01;
                    2:       op = 6'h08;
                    default: begin op = 6'h00; fn = 6'h00; end
                endcase
            end
        endcase
    endtask

    task automatic play(input logic [5:0] op, input logic [5:0] fn, input bit z);
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge clk);
            opcode = op; funct = fn; zero = z;
            mem_if.mem_ready = c.rdy;
            #2;
            chk({cur, ".state"},    32'(state),            32'(c.st));
            chk({cur, ".mem_req"},  32'(mem_if.mem_req),   32'(c.req));
            chk({cur, ".mem_we"},   32'(mem_if.mem_we),    32'(c.we));
            chk({cur, ".i_or_d"},   32'(mem_if.i_or_d),    32'(c.iod));
            chk({cur, ".ir_write"}, 32'(ir_write),         32'(c.irw));
            chk({cur, ".pc_write"}, 32'(pc_write),         32'(c.pcw));
            chk({cur, ".reg_wr"},   32'(reg_write),        32'(c.rw));
            chk({cur, ".illegal"},  32'(illegal),          32'(c.ill));
            chk({cur, ".bus_err"},  32'(bus_err),          32'(c.berr));
            chk({cur, ".alu_op"},   32'(alu_op),           32'(c.aop));
            chk({cur, ".pc_src"},   32'(pc_src),           32'(c.psrc));
            chk({cur, ".m2r"},      32'(mem_to_reg),       32'(c.m2r));
            if (c.rw) chk({cur, ".reg_dst"}, 32'(reg_dst), 32'(c.rdst));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".state"}, 32'(state), 32'(S_RESET));
        chk({tag, ".outs"},
            32'({mem_if.mem_req, mem_if.mem_we, mem_if.i_or_d, ir_write, pc_write,
                 reg_write, reg_dst, mem_to_reg, alu_src_b, pc_src, alu_src_a,
                 alu_op, ext_type, illegal, bus_err}), 32'd0);
    endtask

    task automatic run(input string name, input int k, input int fw, input int mw, input bit z);
        logic [5:0] op, fn;
        cur = name;
        enc(k, op, fn);
        build(k, fw, mw, z);
        play(op, fn, z);
    endtask

    initial begin
        int k, fw, mw;
        bit z;
        opcode = 6'h00; funct = 6'h21; zero = 1'b0;
        mem_if.mem_ready = 1'b1;

        @(negedge clk); #2;
        chk_all_zero("reset");
        rst_n = 1'b1;
        #1 chk("release.state", 32'(state), 32'(S_RESET));

        run("addu",     K_ADDU, 0, 0, 1'b0);
        run("lw.wait3", K_LW,   0, 3, 1'b0);
        run("beq.z1",   K_BEQ,  0, 0, 1'b1);
        run("beq.z0",   K_BEQ,  0, 0, 1'b0);
        run("sw.tmo",   K_SW,   0, 9, 1'b0);
        run("sw.tie",   K_SW,   0, 4, 1'b0);
        cur = "bad3f";
        build(K_BAD, 0, 0, 1'b0);
        play(6'h3F, 6'h00, 1'b0);
        run("jal",      K_JAL,  1, 0, 1'b0);
        run("fetch.tmo",K_ADDU, 7, 0, 1'b0);
        run("lw.tmo",   K_LW,   0, 6, 1'b0);

        for (int i = 0; i < 40; i++) begin
            k  = $urandom_range(0, 13);
            fw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : 0;
            mw = $urandom_range(0, 7);
            z  = 1'($urandom_range(0, 1));
            run($sformatf("r%0d.%s", i, nm[k]), k, fw, mw, z);
        end

        // Reset while a fetch is stalled must silence the port at once.
        cur = "fetchwait";
        for (int i = 0; i < 2; i++) begin
            cyc_t c;
            c = blank(S_FETCH); c.req = 1'b1;
            q.push_back(c);
        end
        play(6'h00, 6'h21, 1'b0);
        @(negedge clk);
        mem_if.mem_ready = 1'b0;
        #2 chk("prerst.mem_req", 32'(mem_if.mem_req), 32'd1);
        rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        @(negedge clk); #2;
        chk_all_zero("holdrst");
        rst_n = 1'b1;
        #1 chk("rerelease.state", 32'(state), 32'(S_RESET));

        for (int i = 0; i < 5; i++) run($sformatf("perf%0d", i), K_ADDU, 0, 0, 1'b0);
`ifdef MIPS_MC_PERF_EN
        @(negedge clk); #2;
        chk("perf.cycle_cnt", 32'(cycle_cnt), 32'd4);
        chk("perf.instr_cnt", 32'(instr_cnt), 32'd5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
